perceptron_trainer: RTL

Parametrised perceptron training engine. Generalises the fixed two-input neuron to `N_IN` signed inputs, with a configurable threshold, learning-rate shift and epoch limit. It fetches training samples from an external sample store through a request/valid handshake. It iterates epochs until an epoch produces no weight change (converged) or the epoch limit is reached, then exposes final weights and bias. It sits beside the sample memory and is driven by the top-level controller via `start`/`done`.

---
 rtl/perceptron_trainer_if.sv | 31 +++
 rtl/perceptron_trainer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/perceptron_trainer_if.sv
// perceptron_trainer_if: control, sample-fetch handshake and result bundle of the perceptron trainer
interface perceptron_trainer_if #(
  parameter int N_IN = 4,
  parameter int XW   = 7,
  parameter int WW   = 14,
  parameter int IDXW = 8,
  parameter int EPW  = 8
);
  logic                 start;
  logic [IDXW-1:0]      n_samples;
  logic [EPW-1:0]       max_epochs;
  logic                 sample_req;
  logic [IDXW-1:0]      sample_idx;
  logic                 sample_valid;
  logic [N_IN*XW-1:0]   sample_x;
  logic [1:0]           sample_t;
  logic [N_IN*WW-1:0]   weights;
  logic [WW-1:0]        bias;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic [EPW-1:0]       epoch_count;
  modport master (
    input  start, n_samples, max_epochs, sample_valid, sample_x, sample_t,
    output sample_req, sample_idx, weights, bias, busy, done, converged, epoch_count
  );
  modport slave (
    output start, n_samples, max_epochs, sample_valid, sample_x, sample_t,
    input  sample_req, sample_idx, weights, bias, busy, done, converged, epoch_count
  );
endinterface

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: epoch-iterating perceptron trainer; PERCEPTRON_SAT_EN clamps updates instead of wrapping
module perceptron_trainer #(
  parameter int N_IN     = 4,
  parameter int XW       = 7,
  parameter int WW       = 14,
  parameter int IDXW     = 8,
  parameter int EPW      = 8,
  parameter int THETA    = 0,
  parameter int LR_SHIFT = 0
) (
  input logic clk,
  input logic rst_n,
  perceptron_trainer_if.master bus
);
  localparam int ACCW = XW + WW + $clog2(N_IN + 1) + 1;
  localparam int UW   = WW + XW + LR_SHIFT + 2;
  localparam int MW   = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam logic signed [ACCW-1:0] TH = ACCW'(THETA);
  localparam logic signed [UW-1:0]   BD = UW'(2 ** LR_SHIFT);
`ifdef PERCEPTRON_SAT_EN
  localparam logic signed [UW-1:0] WMAX = UW'(2 ** (WW - 1) - 1);
  localparam logic signed [UW-1:0] WMIN = -WMAX - UW'(1);
`endif
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, MAC, DECIDE, UPDATE, EPOCH_END, DONE} state_t;
  state_t state, state_n;
  logic [IDXW-1:0]        idx, n_lat;
  logic [EPW-1:0]         max_lat, ep;
  logic                   change, conv;
  logic [N_IN*XW-1:0]     x_lat;
  logic [1:0]             t_lat;
  logic signed [ACCW-1:0] acc, prod;
  logic [MW-1:0]          mi;
  logic signed [WW-1:0]   w [N_IN];
  logic signed [WW-1:0]   w_upd [N_IN];
  logic signed [XW-1:0]   xs [N_IN];
  logic signed [WW-1:0]   b, b_upd;
  logic                   t_pos, t_neg, y_pos, y_neg, need_upd, last;

  function automatic logic signed [WW-1:0] fit(input logic signed [UW-1:0] v);
`ifdef PERCEPTRON_SAT_EN
    fit = v > WMAX ? WW'(WMAX) : v < WMIN ? WW'(WMIN) : WW'(v);
`else
    fit = WW'(v);
`endif
  endfunction

  genvar i;
  for (i = 0; i < N_IN; i++) begin : g_lane
    logic signed [UW-1:0] d;
    assign xs[i] = x_lat[i*XW +: XW];
    assign d = UW'(xs[i]) <<< LR_SHIFT;
    assign w_upd[i] = fit(UW'(w[i]) + (t_neg ? -d : d));
    assign bus.weights[i*WW +: WW] = w[i];
  end

  assign prod     = ACCW'(xs[mi]) * ACCW'(w[mi]);
  assign b_upd    = fit(UW'(b) + (t_neg ? -BD : BD));
  assign t_pos    = t_lat == 2'b01;
  assign t_neg    = t_lat == 2'b11;
  assign y_pos    = acc > TH;
  assign y_neg    = acc < -TH;
  assign need_upd = (t_pos && !y_pos) || (t_neg && !y_neg);
  assign last     = idx == n_lat - 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (bus.start) state_n = bus.n_samples == '0 ? DONE : FETCH;
      FETCH:      state_n = WAIT;
      WAIT:       if (bus.sample_valid) state_n = MAC;
      MAC:        if (mi == MW'(N_IN - 1)) state_n = DECIDE;
      DECIDE:     state_n = need_upd ? UPDATE : last ? EPOCH_END : FETCH;
      UPDATE:     state_n = last ? EPOCH_END : FETCH;
      EPOCH_END:  state_n = (!change || (max_lat != '0 && ep + 1'b1 == max_lat)) ? DONE : FETCH;
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.sample_req  = state == FETCH;
    bus.busy        = !(state inside {IDLE, DONE});
    bus.done        = state == DONE;
    bus.sample_idx  = idx;
    bus.bias        = b;
    bus.converged   = conv;
    bus.epoch_count = ep;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      n_lat   <= '0;
      max_lat <= '0;
      ep      <= '0;
      change  <= 1'b0;
      conv    <= 1'b0;
      x_lat   <= '0;
      t_lat   <= '0;
      acc     <= '0;
      mi      <= '0;
      w       <= '{default: '0};
      b       <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (bus.start) begin
          w       <= '{default: '0};
          b       <= '0;
          ep      <= '0;
          conv    <= bus.n_samples == '0;
          n_lat   <= bus.n_samples;
          max_lat <= bus.max_epochs;
          idx     <= '0;
          change  <= 1'b0;
        end
        WAIT: if (bus.sample_valid) begin
          x_lat <= bus.sample_x;
          t_lat <= bus.sample_t;
          acc   <= ACCW'(b);
          mi    <= '0;
        end
        MAC: begin
          acc <= acc + prod;
          mi  <= mi + 1'b1;
        end
        UPDATE: begin
          w      <= w_upd;
          b      <= b_upd;
          change <= 1'b1;
        end
        EPOCH_END: begin
          if (ep != '1) ep <= ep + 1'b1;
          conv   <= !change;
          idx    <= '0;
          change <= 1'b0;
        end
        default: ;
      endcase
      // the sample index only advances when another sample of the same epoch follows
      if (state inside {DECIDE, UPDATE} && state_n == FETCH) idx <= idx + 1'b1;
    end
  end
endmodule
